// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - Core-local interruptor: mtime, mtimecmp and msip for the single RV64 hart.
// Optional mtime write support is enabled by defining CLINT_MTIME_WR_EN.
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sel,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [63:0] req_addr,
    input  logic [7:0]  req_byte_enable,
    input  logic [63:0] req_wr_data,
    output logic        resp_valid,
    output logic [63:0] resp_rd_data,
    output logic        resp_err,
    output logic        mtip,
    output logic        msip
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
    localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic          r_msip;
    logic [PW-1:0] r_presc;
    logic          r_mtip;
    logic          r_resp_valid;
    logic [63:0]   r_resp_rd_data;
    logic          r_resp_err;

    logic          w_accept;
    logic          w_hit_msip;
    logic          w_hit_cmp;
    logic          w_hit_time;
    logic          w_err;
    logic          w_wr_ok;
    logic          w_wr_msip;
    logic          w_wr_cmp;
    logic          w_tick;
    logic [63:0]   w_mtime_inc;
    logic [63:0]   w_mtime_next;
    logic [63:0]   w_mtimecmp_next;
    logic [PW-1:0] w_presc_next;
    logic [63:0]   w_rd_data;

    function automatic logic [63:0] f_merge(input logic [63:0] old_v,
                                            input logic [63:0] new_v,
                                            input logic [7:0]  be);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    assign sel       = (req_addr[63:16] == BASE_ADDR[63:16]);
    assign req_ready = ~rst;
    assign w_accept  = req_valid & req_ready;

    assign w_hit_msip = (req_addr[15:0] == OFF_MSIP);
    assign w_hit_cmp  = (req_addr[15:0] == OFF_MTIMECMP);
    assign w_hit_time = (req_addr[15:0] == OFF_MTIME);
    assign w_err      = (req_addr[2:0] != 3'b000) | ~(w_hit_msip | w_hit_cmp | w_hit_time);

    assign w_wr_ok   = w_accept & req_wr & ~w_err;
    assign w_wr_msip = w_wr_ok & w_hit_msip & req_byte_enable[0];
    assign w_wr_cmp  = w_wr_ok & w_hit_cmp;

    assign w_tick = (r_presc == PRESC_MAX);

    always_comb begin
        w_mtime_inc     = r_mtime + {63'b0, w_tick};
        w_presc_next    = w_tick ? '0 : r_presc + PW'(1);
        w_mtime_next    = w_mtime_inc;
`ifdef CLINT_MTIME_WR_EN
        // Written lanes override the tick; unwritten lanes keep the incremented value.
        if (w_wr_ok && w_hit_time) begin
            w_mtime_next = f_merge(w_mtime_inc, req_wr_data, req_byte_enable);
            w_presc_next = '0;
        end
`endif
        w_mtimecmp_next = w_wr_cmp ? f_merge(r_mtimecmp, req_wr_data, req_byte_enable)
                                   : r_mtimecmp;
    end

    always_comb begin
        w_rd_data = 64'b0;
        if (!req_wr && !w_err) begin
            if (w_hit_msip)      w_rd_data = {63'b0, r_msip};
            else if (w_hit_cmp)  w_rd_data = r_mtimecmp;
            else if (w_hit_time) w_rd_data = r_mtime;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime        <= 64'b0;
            r_mtimecmp     <= '1;
            r_msip         <= 1'b0;
            r_presc        <= '0;
            r_mtip         <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_rd_data <= 64'b0;
            r_resp_err     <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
            r_presc    <= w_presc_next;
            if (w_wr_msip) begin
                r_msip <= req_wr_data[0];
            end
            // Compare against next-state values so the interrupt lines up with mtime.
            r_mtip         <= (w_mtime_next >= w_mtimecmp_next);
            r_resp_valid   <= w_accept;
            r_resp_rd_data <= w_accept ? w_rd_data : 64'b0;
            r_resp_err     <= w_accept & w_err;
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_rd_data = r_resp_rd_data;
    assign resp_err     = r_resp_err;
    assign mtip         = r_mtip;
    assign msip         = r_msip;

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - Directed table-driven bench for clint_timer (TICK_DIV 1 and 4 instances).
module tb_clint_timer;

    localparam logic [63:0] A = 64'h0000_0000_0200_0000;

    logic        clk;
    logic        rst;
    logic        req_valid, req_valid4;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [7:0]  req_byte_enable;
    logic [63:0] req_wr_data;

    logic        sel, sel4;
    logic        req_ready, req_ready4;
    logic        resp_valid, resp_valid4;
    logic [63:0] resp_rd_data, resp_rd_data4;
    logic        resp_err, resp_err4;
    logic        mtip, mtip4;
    logic        msip, msip4;

    int checks = 0;
    int errors = 0;

    clint_timer #(.BASE_ADDR(A), .TICK_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .sel(sel),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_byte_enable(req_byte_enable), .req_wr_data(req_wr_data),
        .resp_valid(resp_valid), .resp_rd_data(resp_rd_data), .resp_err(resp_err),
        .mtip(mtip), .msip(msip)
    );

    clint_timer #(.BASE_ADDR(A), .TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .sel(sel4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_wr(req_wr),
        .req_addr(req_addr), .req_byte_enable(req_byte_enable), .req_wr_data(req_wr_data),
        .resp_valid(resp_valid4), .resp_rd_data(resp_rd_data4), .resp_err(resp_err4),
        .mtip(mtip4), .msip(msip4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        logic        exp_err;
        logic        exp_msip;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input bit t4, input logic wr, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] wd,
                        output logic [63:0] rd, output logic err, output logic vld);
        req_wr          = wr;
        req_addr        = addr;
        req_byte_enable = be;
        req_wr_data     = wd;
        if (t4) req_valid4 = 1'b1;
        else    req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd  = t4 ? resp_rd_data4 : resp_rd_data;
        err = t4 ? resp_err4     : resp_err;
        vld = t4 ? resp_valid4   : resp_valid;
        req_valid  = 1'b0;
        req_valid4 = 1'b0;
    endtask

    task automatic rd_chk(input bit t4, input string name, input logic [63:0] addr,
                          input logic [63:0] exp);
        logic [63:0] rd;
        logic        err, vld;
        xfer(t4, 1'b0, addr, 8'h00, 64'h0, rd, err, vld);
        chk({name, ".valid"}, {63'b0, vld}, 64'd1);
        chk({name, ".err"},   {63'b0, err}, 64'd0);
        chk({name, ".data"},  rd, exp);
    endtask

    task automatic wr_chk(input bit t4, input string name, input logic [63:0] addr,
                          input logic [7:0] be, input logic [63:0] wd);
        logic [63:0] rd;
        logic        err, vld;
        xfer(t4, 1'b1, addr, be, wd, rd, err, vld);
        chk({name, ".valid"}, {63'b0, vld}, 64'd1);
        chk({name, ".err"},   {63'b0, err}, 64'd0);
        chk({name, ".data"},  rd, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.ready",      {63'b0, req_ready},  64'd0);
        chk("rst.resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst.rd_data",    resp_rd_data,        64'd0);
        chk("rst.err",        {63'b0, resp_err},   64'd0);
        chk("rst.mtip",       {63'b0, mtip},       64'd0);
        chk("rst.msip",       {63'b0, msip},       64'd0);
        chk("rst.mtip4",      {63'b0, mtip4},      64'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] rd;
        logic        err, vld;

        rst = 1'b1;
        req_valid = 1'b0; req_valid4 = 1'b0; req_wr = 1'b0;
        req_addr = 64'h0; req_byte_enable = 8'h0; req_wr_data = 64'h0;

        vecs[0]  = '{1'b1, A + 64'h0000, 8'h01, 64'h3,                   64'h0,                   1'b0, 1'b1};
        vecs[1]  = '{1'b0, A + 64'h0000, 8'h00, 64'h0,                   64'h1,                   1'b0, 1'b1};
        vecs[2]  = '{1'b1, A + 64'h4000, 8'h0F, 64'h1122_3344_5566_7788, 64'h0,                   1'b0, 1'b1};
        vecs[3]  = '{1'b0, A + 64'h4000, 8'h00, 64'h0,                   64'hFFFF_FFFF_5566_7788, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, A + 64'h4000, 8'hF0, 64'hAABB_CCDD_0000_0000, 64'h0,                   1'b0, 1'b1};
        vecs[5]  = '{1'b0, A + 64'h4000, 8'h00, 64'h0,                   64'hAABB_CCDD_5566_7788, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, A + 64'h4004, 8'h00, 64'h0,                   64'h0,                   1'b1, 1'b1};
        vecs[7]  = '{1'b0, A + 64'h1000, 8'h00, 64'h0,                   64'h0,                   1'b1, 1'b1};
        vecs[8]  = '{1'b1, A + 64'h4004, 8'hFF, 64'h0,                   64'h0,                   1'b1, 1'b1};
        vecs[9]  = '{1'b0, A + 64'h4000, 8'h00, 64'h0,                   64'hAABB_CCDD_5566_7788, 1'b0, 1'b1};
        vecs[10] = '{1'b1, A + 64'h0000, 8'h00, 64'h0,                   64'h0,                   1'b0, 1'b1};
        vecs[11] = '{1'b0, A + 64'h0000, 8'h00, 64'h0,                   64'h1,                   1'b0, 1'b1};
        vecs[12] = '{1'b1, A + 64'h0000, 8'hFE, 64'h0,                   64'h0,                   1'b0, 1'b1};
        vecs[13] = '{1'b1, A + 64'h0000, 8'h01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0,                   1'b0, 1'b0};
        vecs[14] = '{1'b0, A + 64'h0000, 8'h00, 64'h0,                   64'h0,                   1'b0, 1'b0};
        vecs[15] = '{1'b1, A + 64'h0008, 8'hFF, 64'h1,                   64'h0,                   1'b1, 1'b0};
        vecs[16] = '{1'b0, A + 64'hBFF0, 8'h00, 64'h0,                   64'h0,                   1'b1, 1'b0};
        vecs[17] = '{1'b1, A + 64'h0001, 8'h01, 64'h1,                   64'h0,                   1'b1, 1'b0};

        @(negedge clk);
        do_reset();

        // Free-running mtime, TICK_DIV=1 and TICK_DIV=4
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            chk("idle.mtip", {63'b0, mtip}, 64'd0);
            chk("idle.msip", {63'b0, msip}, 64'd0);
        end
        rd_chk(1'b0, "mtime_div1", A + 64'hBFF8, 64'd10);
        repeat (29) @(negedge clk);
        rd_chk(1'b1, "mtime_div4_a", A + 64'hBFF8, 64'd10);
        rd_chk(1'b1, "mtime_div4_b", A + 64'hBFF8, 64'd10);
        rd_chk(1'b1, "mtime_div4_c", A + 64'hBFF8, 64'd10);
        rd_chk(1'b1, "mtime_div4_d", A + 64'hBFF8, 64'd10);
        rd_chk(1'b1, "mtime_div4_e", A + 64'hBFF8, 64'd11);

        // Timer interrupt rises exactly as mtime reaches mtimecmp
        do_reset();
        repeat (5) @(negedge clk);
        wr_chk(1'b0, "cmp20", A + 64'h4000, 8'hFF, 64'd20);
        for (int n = 6; n <= 22; n++) begin
            chk($sformatf("mtip_at_%0d", n), {63'b0, mtip}, (n >= 20) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        wr_chk(1'b0, "cmp_ones", A + 64'h4000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mtip_clear", {63'b0, mtip}, 64'd0);
        rd_chk(1'b0, "mtime_24", A + 64'hBFF8, 64'd24);
        rd_chk(1'b0, "cmp_back", A + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF);

        // Table-driven register/decode vectors
        do_reset();
        for (int i = 0; i < 18; i++) begin
            xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, rd, err, vld);
            chk($sformatf("vec%0d.valid", i), {63'b0, vld}, 64'd1);
            chk($sformatf("vec%0d.data", i),  rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d.err", i),   {63'b0, err}, {63'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d.msip", i),  {63'b0, msip}, {63'b0, vecs[i].exp_msip});
        end
        @(negedge clk);
        chk("resp_pulse", {63'b0, resp_valid}, 64'd0);

        // Address window decode
        req_addr = A + 64'h4000;          #1 chk("sel_in",   {63'b0, sel}, 64'd1);
        req_addr = A + 64'hFFFF;          #1 chk("sel_top",  {63'b0, sel}, 64'd1);
        req_addr = A + 64'h1_0000;        #1 chk("sel_next", {63'b0, sel}, 64'd0);
        req_addr = A | 64'h1000_0000_0000_0000; #1 chk("sel_high", {63'b0, sel}, 64'd0);
        @(negedge clk);

        // Reset with a request pending: no response, state back to reset values
        wr_chk(1'b0, "msip_set", A, 8'h01, 64'h1);
        wr_chk(1'b0, "cmp_set", A + 64'h4000, 8'hFF, 64'h0);
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = A;
        #1 chk("rst_ready", {63'b0, req_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_drop", {63'b0, resp_valid}, 64'd0);
        chk("rst_msip", {63'b0, msip}, 64'd0);
        chk("rst_mtip", {63'b0, mtip}, 64'd0);
        req_valid = 1'b0; rst = 1'b0;
        rd_chk(1'b0, "rst_msip_rd", A, 64'd0);
        rd_chk(1'b0, "rst_cmp_rd", A + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF);

        // mtime write behaviour
        do_reset();
        repeat (3) @(negedge clk);
        wr_chk(1'b0, "mtime_wr", A + 64'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
`ifdef CLINT_MTIME_WR_EN
        rd_chk(1'b0, "wrap_a", A + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE);
        rd_chk(1'b0, "wrap_b", A + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_chk(1'b0, "wrap_c", A + 64'hBFF8, 64'h0);
        wr_chk(1'b0, "mtime_lane", A + 64'hBFF8, 8'h0F, 64'hFFFF_FFFF_1000_0000);
        rd_chk(1'b0, "lane_rd", A + 64'hBFF8, 64'h0000_0000_1000_0000);
`else
        rd_chk(1'b0, "ro_a", A + 64'hBFF8, 64'd4);
        rd_chk(1'b0, "ro_b", A + 64'hBFF8, 64'd5);
        rd_chk(1'b0, "ro_c", A + 64'hBFF8, 64'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
